// File: rtl/ym6045c_z80_bank_bridge.sv
// ym6045c_z80_bank_bridge: Z80 8000-FFFF window onto the 68k bus.
// A 9-bit bank register, loaded serially through writes to page BANK_PAGE,
// supplies 68k A[23:15]. Each window access requests the bus (BR/BG/BGACK),
// runs one byte cycle, and holds the Z80 in WAIT until the cycle ends.
// Optional macro YM6045C_BUS_TIMEOUT_EN adds a DTACK timeout with a sticky bus_err.
module ym6045c_z80_bank_bridge #(
  parameter logic [7:0] BANK_PAGE   = 8'h60,
  parameter logic [7:0] TIMEOUT_CYC = 8'd200
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [15:0] z_addr,
  input  logic        z_rd,
  input  logic        z_wr,
  input  logic [7:0]  z_wdata,
  output logic [7:0]  z_rdata,
  output logic        z_wait_n,
  output logic        m_br_n,
  input  logic        m_bg_n,
  output logic        m_bgack_n,
  output logic        m_as_n,
  output logic        m_uds_n,
  output logic        m_lds_n,
  output logic        m_rw,
  output logic [22:0] m_addr,
  output logic [15:0] m_dout,
  input  logic [15:0] m_din,
  input  logic        m_dtack_n,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACK, S_ADDR, S_DTACK, S_END
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  bank_q, bank_d;
  logic [14:0] lat_addr_q, lat_addr_d;   // bit 15 is always 1 inside the window
  logic [7:0]  lat_data_q, lat_data_d;
  logic        lat_wr_q, lat_wr_d;
  logic        bg_seen_q, bg_seen_d;     // grant seen low on the previous edge
  logic [22:0] m_addr_q, m_addr_d;
  logic [15:0] m_dout_q, m_dout_d;
  logic        m_rw_q, m_rw_d;
  logic [7:0]  z_rdata_q, z_rdata_d;
`ifdef YM6045C_BUS_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  logic in_cycle;

  // Bus strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    in_cycle  = (state_q == S_ADDR) || (state_q == S_DTACK);
    z_wait_n  = (state_q == S_IDLE);
    m_br_n    = (state_q != S_REQ);
    m_bgack_n = !((state_q == S_ACK) || in_cycle);
    m_as_n    = !in_cycle;
    m_uds_n   = !(in_cycle && !lat_addr_q[0]);
    m_lds_n   = !(in_cycle &&  lat_addr_q[0]);
  end

  assign z_rdata = z_rdata_q;
  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_dout  = m_dout_q;
`ifdef YM6045C_BUS_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Next-state logic: strobe acceptance, arbitration and the byte cycle.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    lat_wr_d   = lat_wr_q;
    bg_seen_d  = 1'b0;
    m_addr_d   = m_addr_q;
    m_dout_d   = m_dout_q;
    m_rw_d     = m_rw_q;
    z_rdata_d  = z_rdata_q;
`ifdef YM6045C_BUS_TIMEOUT_EN
    cnt_d      = 8'd0;
    bus_err_d  = bus_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (z_wr && (z_addr[15:8] == BANK_PAGE)) begin
          bank_d = {z_wdata[0], bank_q[8:1]};
        end else if (z_addr[15] && (z_rd || z_wr)) begin
          lat_addr_d = z_addr[14:0];
          lat_data_d = z_wdata;
          lat_wr_d   = z_wr;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        // Grant must be seen low on two consecutive edges.
        if (!m_bg_n) begin
          bg_seen_d = 1'b1;
          if (bg_seen_q) begin
            m_addr_d = {bank_q, lat_addr_q[14:1]};
            m_dout_d = {lat_data_q, lat_data_q};
            m_rw_d   = !lat_wr_q;
            state_d  = S_ACK;
          end
        end
      end
      S_ACK:  state_d = S_ADDR;
      S_ADDR: state_d = S_DTACK;
      S_DTACK: begin
        if (!m_dtack_n) begin
          if (!lat_wr_q) z_rdata_d = lat_addr_q[0] ? m_din[7:0] : m_din[15:8];
          state_d = S_END;
        end
`ifdef YM6045C_BUS_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CYC) begin
            bus_err_d = 1'b1;
            z_rdata_d = 8'hFF;
            state_d   = S_END;
          end
        end
`endif
      end
      S_END: begin
        m_rw_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q    <= S_IDLE;
      bank_q     <= 9'd0;
      lat_addr_q <= 15'd0;
      lat_data_q <= 8'd0;
      lat_wr_q   <= 1'b0;
      bg_seen_q  <= 1'b0;
      m_addr_q   <= 23'd0;
      m_dout_q   <= 16'd0;
      m_rw_q     <= 1'b1;
      z_rdata_q  <= 8'hFF;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      lat_wr_q   <= lat_wr_d;
      bg_seen_q  <= bg_seen_d;
      m_addr_q   <= m_addr_d;
      m_dout_q   <= m_dout_d;
      m_rw_q     <= m_rw_d;
      z_rdata_q  <= z_rdata_d;
    end
  end

`ifdef YM6045C_BUS_TIMEOUT_EN
  // DTACK timeout counter and sticky abort flag.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_ym6045c_z80_bank_bridge.sv
// Bench for ym6045c_z80_bank_bridge: table of window accesses with expected
// 68k bus fields, read data and WAIT length, checked through a scoreboard queue;
// plus hand sequences for reset, ignored strobes, mid-access reset and timeout.
module tb_ym6045c_z80_bank_bridge;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic [15:0] z_addr = 16'h0;
  logic        z_rd = 1'b0, z_wr = 1'b0;
  logic [7:0]  z_wdata = 8'h0;
  logic [7:0]  z_rdata;
  logic        z_wait_n, m_br_n, m_bgack_n, m_as_n, m_uds_n, m_lds_n, m_rw, bus_err;
  logic        m_bg_n = 1'b1, m_dtack_n = 1'b1;
  logic [22:0] m_addr;
  logic [15:0] m_dout;
  logic [15:0] m_din = 16'h0;

  int tests = 0, fails = 0;
  int grant_delay = 0, gcnt = 0;
  bit dtack_en = 1'b1;

  typedef struct {
    int          pre_n;      // bank writes issued before the access
    logic [8:0]  pre_bits;   // bit i = data bit0 of bank write i
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] din;
    int          gdelay;     // grant comes after this many negedges of BR low
    bit          inj;        // bank-page write attempted mid-access
    logic [22:0] exp_addr;
    logic        exp_uds_n, exp_lds_n, exp_rw;
    logic [15:0] exp_dout;
    logic [7:0]  exp_rdata;
    int          exp_wait;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  ym6045c_z80_bank_bridge dut (
    .CLK(CLK), .RES(RES), .z_addr(z_addr), .z_rd(z_rd), .z_wr(z_wr),
    .z_wdata(z_wdata), .z_rdata(z_rdata), .z_wait_n(z_wait_n),
    .m_br_n(m_br_n), .m_bg_n(m_bg_n), .m_bgack_n(m_bgack_n), .m_as_n(m_as_n),
    .m_uds_n(m_uds_n), .m_lds_n(m_lds_n), .m_rw(m_rw), .m_addr(m_addr),
    .m_dout(m_dout), .m_din(m_din), .m_dtack_n(m_dtack_n), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // 68k-side responder: grant after grant_delay negedges of BR, DTACK on AS.
  always @(negedge CLK) begin
    if (!m_br_n) begin
      gcnt   = gcnt + 1;
      m_bg_n = (gcnt > grant_delay) ? 1'b0 : 1'b1;
    end else begin
      gcnt   = 0;
      m_bg_n = 1'b1;
    end
    m_dtack_n = (dtack_en && !m_as_n) ? 1'b0 : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bank_wr(input logic b);
    @(negedge CLK);
    z_addr = 16'h6000; z_wdata = {7'b1010010, b}; z_wr = 1'b1;
    @(posedge CLK); #1 z_wr = 1'b0;
  endtask

  task automatic do_access(input vec_t v);
    vec_t e;
    int   wcnt;
    bit   seen, done;
    for (int i = 0; i < v.pre_n; i++) bank_wr(v.pre_bits[i]);
    grant_delay = v.gdelay;
    m_din = v.din;
    @(negedge CLK);
    z_addr = v.addr; z_wdata = v.wdata; z_rd = !v.is_wr; z_wr = v.is_wr;
    sb.push_back(v);
    @(posedge CLK); #1 z_rd = 1'b0; z_wr = 1'b0;
    wcnt = 0; seen = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge CLK);
      if (v.inj && i == 0) begin
        z_addr = 16'h6000; z_wdata = 8'h00; z_wr = 1'b1;
      end
      if (v.inj && i == 1) z_wr = 1'b0;
      if (!m_as_n && !seen) begin
        seen = 1;
        e = sb[0];
        chk("m_addr", {9'd0, m_addr}, {9'd0, e.exp_addr});
        chk("m_uds_n", {31'd0, m_uds_n}, {31'd0, e.exp_uds_n});
        chk("m_lds_n", {31'd0, m_lds_n}, {31'd0, e.exp_lds_n});
        chk("m_rw", {31'd0, m_rw}, {31'd0, e.exp_rw});
        if (e.is_wr) chk("m_dout", {16'd0, m_dout}, {16'd0, e.exp_dout});
      end
      if (z_wait_n) done = 1;
      else wcnt++;
    end
    if (!done) chk("wait_rise", 32'd0, 32'd1);
    if (!seen) chk("as_seen", 32'd0, 32'd1);
    e = sb.pop_front();
    chk("wait_cycles", wcnt, e.exp_wait);
    if (!e.is_wr) chk("z_rdata", {24'd0, z_rdata}, {24'd0, e.exp_rdata});
  endtask

  initial begin
    vec_t v;
    bit   as_ok;
    // Bank 0 from reset, odd byte, grant late: 6 + 3 = 9 WAIT cycles.
    vecs[0] = '{0, 9'h000, 1'b0, 16'h8003, 8'h00, 16'h12AB, 3, 1'b0,
                23'h000001, 1'b1, 1'b0, 1'b1, 16'h0000, 8'hAB, 9};
    // Bits 1,0,1,0,1,0,1,0,1 shift in from the top -> bank 9'h155;
    // {9'h155, 14'h0001} = 23'h554001.
    vecs[1] = '{9, 9'h155, 1'b0, 16'h8002, 8'h00, 16'h34CD, 0, 1'b0,
                23'h554001, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h34, 6};
    // Write with a bank-page write attempted mid-access (must be ignored).
    vecs[2] = '{0, 9'h000, 1'b1, 16'h8000, 8'h5A, 16'h0000, 0, 1'b1,
                23'h554000, 1'b0, 1'b1, 1'b0, 16'h5A5A, 8'h00, 6};
    // Top of the window; bank still 9'h155.
    vecs[3] = '{0, 9'h000, 1'b0, 16'hFFFF, 8'h00, 16'hBEEF, 0, 1'b0,
                23'h557FFF, 1'b1, 1'b0, 1'b1, 16'h0000, 8'hEF, 6};
    // Odd write, grant one cycle late -> 7 WAIT cycles.
    vecs[4] = '{0, 9'h000, 1'b1, 16'hC001, 8'h81, 16'h0000, 1, 1'b0,
                23'h556000, 1'b1, 1'b0, 1'b0, 16'h8181, 8'h00, 7};
    // One more bank write of 0 -> bank 9'h0AA -> 23'h2A8001.
    vecs[5] = '{1, 9'h000, 1'b0, 16'h8002, 8'h00, 16'h9E00, 0, 1'b0,
                23'h2A8001, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h9E, 6};

    // Reset with strobes active.
    z_addr = 16'h8000; z_rd = 1'b1; z_wr = 1'b1; z_wdata = 8'h77;
    repeat (3) @(negedge CLK);
    chk("rst_wait_n", {31'd0, z_wait_n}, 32'd1);
    chk("rst_br_n", {31'd0, m_br_n}, 32'd1);
    chk("rst_bgack_n", {31'd0, m_bgack_n}, 32'd1);
    chk("rst_strobes", {29'd0, m_as_n, m_uds_n, m_lds_n}, 32'd7);
    chk("rst_rw", {31'd0, m_rw}, 32'd1);
    chk("rst_addr", {9'd0, m_addr}, 32'd0);
    chk("rst_dout", {16'd0, m_dout}, 32'd0);
    chk("rst_rdata", {24'd0, z_rdata}, 32'h0000_00FF);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    z_rd = 1'b0; z_wr = 1'b0;
    RES = 1'b1;

    for (int i = 0; i < 5; i++) do_access(vecs[i]);

    // Strobes outside the window and reads of the bank page are ignored.
    @(negedge CLK); z_addr = 16'h1234; z_wr = 1'b1; z_wdata = 8'hFF;
    @(posedge CLK); #1 z_wr = 1'b0;
    @(negedge CLK); z_addr = 16'h6000; z_rd = 1'b1; z_wdata = 8'hFF;
    @(posedge CLK); #1 z_rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("ignored_strobe", {30'd0, z_wait_n, m_br_n}, 32'd3);
    end

    do_access(vecs[5]);

    // Reset in S_DTACK releases the bus immediately.
    dtack_en = 1'b0; grant_delay = 0;
    @(negedge CLK); z_addr = 16'h8001; z_rd = 1'b1;
    @(posedge CLK); #1 z_rd = 1'b0;
    as_ok = 0;
    for (int i = 0; i < 20 && !as_ok; i++) begin
      @(negedge CLK);
      if (!m_as_n) as_ok = 1;
    end
    chk("midrst_as_seen", {31'd0, as_ok}, 32'd1);
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    #1;
    chk("midrst_as_n", {31'd0, m_as_n}, 32'd1);
    chk("midrst_bgack_n", {31'd0, m_bgack_n}, 32'd1);
    chk("midrst_br_n", {31'd0, m_br_n}, 32'd1);
    chk("midrst_wait_n", {31'd0, z_wait_n}, 32'd1);
    chk("midrst_lane", {30'd0, m_uds_n, m_lds_n}, 32'd3);
    @(negedge CLK); RES = 1'b1; dtack_en = 1'b1;
    // Bank was cleared by reset.
    v = '{0, 9'h000, 1'b0, 16'h8001, 8'h00, 16'h0077, 0, 1'b0,
          23'h000000, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h77, 6};
    do_access(v);

`ifdef YM6045C_BUS_TIMEOUT_EN
    // DTACK never comes: 4 cycles to reach S_DTACK + 200 there + 1 in S_END.
    dtack_en = 1'b0;
    v = '{0, 9'h000, 1'b0, 16'h8000, 8'h00, 16'h1234, 0, 1'b0,
          23'h000000, 1'b0, 1'b1, 1'b1, 16'h0000, 8'hFF, 205};
    do_access(v);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    dtack_en = 1'b1;
    v = '{0, 9'h000, 1'b0, 16'h8002, 8'h00, 16'h5511, 0, 1'b0,
          23'h000001, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h55, 6};
    do_access(v);
    chk("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);
`else
    chk("bus_err_tied", {31'd0, bus_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
